// File: rtl/operand_mem_server.sv
// ---------------------------------------------------------------------------
// operand_mem_server
//
// Memory-side responder for the shift-and-normalize multiplier controller.
// It serves one-cycle `read` strobes with operands in order (A then B for each
// pair). It stores results from `write` strobes. Once N_PAIRS results have
// been written it raises `pairs_done`, which feeds the controller's loop-exit
// input.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   clr          : job restart; zeroes pointers/flags, keeps memory contents
//   read         : operand request strobe   -> rd_data / rd_valid
//   write        : result write strobe      <- wr_data
//   pairs_done   : all N_PAIRS results written (registered)
//   err          : sticky protocol error, cleared only by rst
//   ld_en/ld_addr/ld_data : operand preload port
//   res_addr     : result readback address  -> res_data (1-cycle latency)
//
// Configuration macro
//   SRV_RD_PIPE_EN : adds an output register stage on the read path
//                    (read latency 2 instead of 1, full throughput kept).
// ---------------------------------------------------------------------------
module operand_mem_server #(
   parameter  int DATA_W   = 8,
   parameter  int OUT_W    = 16,
   parameter  int N_PAIRS  = 8,
   localparam int OP_DEPTH = 2 * N_PAIRS,
   localparam int OP_AW    = $clog2(OP_DEPTH),
   localparam int RES_AW   = $clog2(N_PAIRS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              read,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              write,
   input  logic [OUT_W-1:0]  wr_data,
   output logic              pairs_done,
   output logic              err,
   input  logic              ld_en,
   input  logic [OP_AW-1:0]  ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [RES_AW-1:0] res_addr,
   output logic [OUT_W-1:0]  res_data
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_COMPLETE = 2'd2
   } state_t;

   localparam logic [RES_AW-1:0] WR_LAST = RES_AW'(N_PAIRS - 1);

   logic [DATA_W-1:0] op_mem  [OP_DEPTH];
   logic [OUT_W-1:0]  res_mem [N_PAIRS];

   state_t            state_r;
   state_t            state_nxt_s;
   logic [OP_AW-1:0]  rd_ptr_r;
   logic [RES_AW-1:0] wr_ptr_r;
   logic              rd_fire_s;
   logic              wr_fire_s;
   logic              err_set_s;
   logic              pairs_done_r;
   logic              err_r;
   logic [DATA_W-1:0] rd_data_r;
   logic              rd_valid_r;
   logic [OUT_W-1:0]  res_data_r;

   // Next-state and strobe qualification; clr overrides everything and
   // silently drops any strobe arriving with it.
   always_comb begin
      state_nxt_s = state_r;
      rd_fire_s   = 1'b0;
      wr_fire_s   = 1'b0;
      err_set_s   = 1'b0;
      if (clr) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rd_fire_s = read;
               err_set_s = write;
               if (read) begin
                  state_nxt_s = ST_ACTIVE;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               rd_fire_s = read;
               wr_fire_s = write;
               if (write && (wr_ptr_r == WR_LAST)) begin
                  state_nxt_s = ST_COMPLETE;
               end else begin
                  state_nxt_s = ST_ACTIVE;
               end
            end
            ST_COMPLETE: begin
               err_set_s   = read | write;
               state_nxt_s = ST_COMPLETE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Read/write pointers; the read pointer wraps naturally over the
   // power-of-two operand depth.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rd_ptr_r <= {OP_AW{1'b0}};
         wr_ptr_r <= {RES_AW{1'b0}};
      end else begin
         if (rd_fire_s) begin
            rd_ptr_r <= rd_ptr_r + OP_AW'(1);
         end
         if (wr_fire_s) begin
            wr_ptr_r <= wr_ptr_r + RES_AW'(1);
         end
      end
   end

   // Completion flag follows the FSM, so it rises right after the last write.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pairs_done_r <= 1'b0;
      end else begin
         pairs_done_r <= (state_nxt_s == ST_COMPLETE);
      end
   end

   // Sticky protocol error; clr deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | err_set_s;
      end
   end

   // Operand preload; the memory is not reset.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         op_mem[ld_addr] <= ld_data;
      end
   end

   // Result storage; the memory is not reset.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         res_mem[wr_ptr_r] <= wr_data;
      end
   end

   // Result readback; a same-cycle write to that address still returns the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data_r <= {OUT_W{1'b0}};
      end else begin
         res_data_r <= res_mem[res_addr];
      end
   end

`ifdef SRV_RD_PIPE_EN
   logic [DATA_W-1:0] rd_data_p_r;
   logic              rd_valid_p_r;

   // First read stage: memory access (read-before-write vs. preload).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_p_r  <= {DATA_W{1'b0}};
         rd_valid_p_r <= 1'b0;
      end else if (clr) begin
         rd_valid_p_r <= 1'b0;
      end else begin
         rd_valid_p_r <= rd_fire_s;
         if (rd_fire_s) begin
            rd_data_p_r <= op_mem[rd_ptr_r];
         end
      end
   end

   // Output stage: rd_data holds its last value between valid pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r  <= {DATA_W{1'b0}};
         rd_valid_r <= 1'b0;
      end else if (clr) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_valid_p_r;
         if (rd_valid_p_r) begin
            rd_data_r <= rd_data_p_r;
         end
      end
   end
`else
   // Single read stage: rd_data holds its last value between valid pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r  <= {DATA_W{1'b0}};
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_fire_s;
         if (rd_fire_s) begin
            rd_data_r <= op_mem[rd_ptr_r];
         end
      end
   end
`endif

   assign rd_data    = rd_data_r;
   assign rd_valid   = rd_valid_r;
   assign pairs_done = pairs_done_r;
   assign err        = err_r;
   assign res_data   = res_data_r;

endmodule

// File: tb/tb_operand_mem_server.sv
// Scoreboard bench for operand_mem_server: expected operands are queued when
// each read is issued. A negedge monitor checks data and arrival cycle.
module tb_operand_mem_server;

`ifdef SRV_RD_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        read = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        write = 1'b0;
   logic [15:0] wr_data = 16'h0000;
   logic        pairs_done;
   logic        err;
   logic        ld_en = 1'b0;
   logic [3:0]  ld_addr = 4'd0;
   logic [7:0]  ld_data = 8'd0;
   logic [2:0]  res_addr = 3'd0;
   logic [15:0] res_data;

   operand_mem_server #(.DATA_W(8), .OUT_W(16), .N_PAIRS(8)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .read(read), .rd_data(rd_data), .rd_valid(rd_valid),
      .write(write), .wr_data(wr_data),
      .pairs_done(pairs_done), .err(err),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .res_addr(res_addr), .res_data(res_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [7:0] data;
   } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] op_tab [16] = '{8'd3, 8'd5, 8'd255, 8'd255, 8'd7, 8'd9, 8'd16, 8'd32,
                              8'd100, 8'd2, 8'd1, 8'd1, 8'd0, 8'd200, 8'd128, 8'd64};

   // Monitor: every rd_valid must match the oldest queued operand on its due cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         e = sb_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL rd_missing: no rd_valid seen, required data %0d at cycle %0d (now %0d)",
                  e.data, e.due, cyc);
      end
      if (rd_valid === 1'b1) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL rd_unexpected: rd_valid with data %0d at cycle %0d, none required",
                     rd_data, cyc);
         end else begin
            e = sb_q.pop_front();
            if (rd_data !== e.data || cyc != e.due) begin
               n_bad++;
               $display("FAIL rd_data: got %0d at cycle %0d, required %0d at cycle %0d",
                        rd_data, cyc, e.data, e.due);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_read(input logic [7:0] exp_data);
      exp_t e;
      e.due  = cyc + LAT;
      e.data = exp_data;
      sb_q.push_back(e);
      read = 1'b1;
      tick();
      read = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] d);
      write   = 1'b1;
      wr_data = d;
      tick();
      write   = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_pairs_done", 32'(pairs_done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      rst = 1'b0;

      // Preload operands
      for (int i = 0; i < 16; i++) begin
         ld_en   = 1'b1;
         ld_addr = 4'(i);
         ld_data = op_tab[i];
         tick();
      end
      ld_en = 1'b0;

      // Full job: read A, read B, write result per pair
      for (int i = 0; i < 8; i++) begin
         do_read(op_tab[2*i]);
         do_read(op_tab[2*i+1]);
         if (i == 7) check("pairs_done_before_last", 32'(pairs_done), 32'd0);
         do_write(16'(i*16 + 1));
         if (i == 7) check("pairs_done_after_last", 32'(pairs_done), 32'd1);
      end
      check("err_full_job", 32'(err), 32'd0);

      // Result readback
      res_addr = 3'd1;
      tick();
      check("res_addr1", 32'(res_data), 32'h0011);
      res_addr = 3'd7;
      tick();
      check("res_addr7", 32'(res_data), 32'h0071);
      res_addr = 3'd4;
      tick();
      check("res_addr4", 32'(res_data), 32'h0041);
      check("pairs_done_hold", 32'(pairs_done), 32'd1);

      // Wrap: clr restarts the job
      idle(2);
      do_clr();
      check("pairs_done_clr", 32'(pairs_done), 32'd0);
      do_read(8'd3);
      idle(2);

      // Collision: read and preload of address 0 in the same cycle
      do_clr();
      read    = 1'b1;
      ld_en   = 1'b1;
      ld_addr = 4'd0;
      ld_data = 8'd9;
      begin
         exp_t e;
         e.due  = cyc + LAT;
         e.data = 8'd3;
         sb_q.push_back(e);
      end
      tick();
      read  = 1'b0;
      ld_en = 1'b0;
      idle(2);
      do_clr();
      do_read(8'd9);
      idle(2);

      // clr with read: strobe dropped, no error
      clr  = 1'b1;
      read = 1'b1;
      tick();
      clr  = 1'b0;
      read = 1'b0;
      idle(2);
      check("err_clr_read", 32'(err), 32'd0);

      // Restore operand 0
      ld_en   = 1'b1;
      ld_addr = 4'd0;
      ld_data = 8'd3;
      tick();
      ld_en = 1'b0;

      // Protocol error: write in IDLE
      res_addr = 3'd0;
      do_write(16'hBEEF);
      check("err_write_idle", 32'(err), 32'd1);
      tick();
      check("res_unchanged", 32'(res_data), 32'h0001);
      do_clr();
      check("err_after_clr", 32'(err), 32'd1);
      rst = 1'b1;
      tick();
      check("err_after_rst", 32'(err), 32'd0);
      rst = 1'b0;

      // Mid-job reset after three reads
      do_read(8'd3);
      do_read(8'd5);
      do_read(8'd255);
      idle(2);
      rst = 1'b1;
      tick();
      check("mid_rst_rd_data", 32'(rd_data), 32'd0);
      check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("mid_rst_pairs_done", 32'(pairs_done), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_res_data", 32'(res_data), 32'd0);
      rst = 1'b0;
      do_read(8'd3);
      idle(3);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
